// File: rtl/ysyx_pkg.sv
// ysyx_pkg: shared definitions for the multi-cycle RV32I/RV32E core.
//   - major opcode encodings of the supported instruction classes
//   - funct3 codes for the ALU and the conditional branches
//   - the EBREAK encoding and the FSM state type
package ysyx_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/ysyx_regfile.sv
// ysyx_regfile: architectural integer register file.
//   clk, rst            clock, asynchronous active-low reset (clears every register)
//   i_raddr1/o_rdata1   operand read port 1 (combinational)
//   i_raddr2/o_rdata2   operand read port 2 (combinational)
//   i_dbg_addr/o_dbg_data debug read port (combinational)
//   i_we/i_waddr/i_wdata synchronous write port
// x0 is not stored: it reads 0 and ignores writes. Indexes >= NR_REG read 0 and
// are never written. Reads see the value before a same-cycle write.
module ysyx_regfile #(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_raddr1,
    output logic [XLEN-1:0] o_rdata1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata2,
    input  logic [4:0]      i_dbg_addr,
    output logic [XLEN-1:0] o_dbg_data,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int AW = $clog2(NR_REG);

    logic [XLEN-1:0] r_regs [1:NR_REG-1];
    logic [NR_REG-1:1] w_wen;
    logic [4:0]      w_raddr [3];
    logic [XLEN-1:0] w_rdata [3];

    genvar gi;

    // One write-enable decode per stored register; x0 has no entry.
    generate
        for (gi = 1; gi < NR_REG; gi++) begin : g_wen
            assign w_wen[gi] = i_we && (i_waddr == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NR_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NR_REG; i++) begin
                if (w_wen[i]) begin
                    r_regs[i] <= i_wdata;
                end
            end
        end
    end

    assign w_raddr[0] = i_raddr1;
    assign w_raddr[1] = i_raddr2;
    assign w_raddr[2] = i_dbg_addr;

    // Bit 4 only addresses a register when all 32 are implemented.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            assign w_rdata[gi] = ((w_raddr[gi] != 5'd0) && ((NR_REG == 32) || !w_raddr[gi][4]))
                               ? r_regs[w_raddr[gi][AW-1:0]] : '0;
        end
    endgenerate

    assign o_rdata1   = w_rdata[0];
    assign o_rdata2   = w_rdata[1];
    assign o_dbg_data = w_rdata[2];

endmodule

// File: rtl/ysyx_mc_core.sv
// ysyx_mc_core: multi-cycle RV32I/RV32E core (FETCH -> WAIT -> EXEC, HALT terminal).
//   clk, rst                 clock, asynchronous active-low reset
//   ifu_req_*                fetch request (valid/ready, addr = pc)
//   ifu_resp_*               fetch response (valid/ready, inst, err)
//   commit, commit_pc        one-cycle pulse and PC per retired instruction
//   halt, fault              sticky stop indication and fault cause
//   pc                       current PC
//   dbg_rf_addr/dbg_rf_data  combinational register-file peek
module ysyx_mc_core
    import ysyx_pkg::*;
#(
    parameter int              XLEN   = 32,
    parameter int              NR_REG = 32,
    parameter logic [XLEN-1:0] RST_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ifu_req_valid,
    input  logic            ifu_req_ready,
    output logic [XLEN-1:0] ifu_req_addr,
    input  logic            ifu_resp_valid,
    output logic            ifu_resp_ready,
    input  logic [31:0]     ifu_resp_inst,
    input  logic            ifu_resp_err,
    output logic            commit,
    output logic [XLEN-1:0] commit_pc,
    output logic            halt,
    output logic            fault,
    output logic [XLEN-1:0] pc,
    input  logic [4:0]      dbg_rf_addr,
    output logic [XLEN-1:0] dbg_rf_data
);

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_fault;

    // Decode fields
    logic [6:0] w_opcode, w_f7;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic [2:0] w_f3;
    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    logic [XLEN-1:0] w_imm_i, w_imm_b, w_imm_u, w_imm_j;
    assign w_imm_i = XLEN'($signed(r_ir[31:20]));
    assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));

    logic [XLEN-1:0] w_rs1_val, w_rs2_val;
    logic            w_rf_we;
    logic [XLEN-1:0] w_wdata;

    ysyx_regfile #(
        .XLEN   (XLEN),
        .NR_REG (NR_REG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_raddr1   (w_rs1),
        .o_rdata1   (w_rs1_val),
        .i_raddr2   (w_rs2),
        .o_rdata2   (w_rs2_val),
        .i_dbg_addr (dbg_rf_addr),
        .o_dbg_data (dbg_rf_data),
        .i_we       (w_rf_we),
        .i_waddr    (w_rd),
        .i_wdata    (w_wdata)
    );

    // Legality and register usage
    logic w_legal, w_ebreak, w_use_rd, w_use_rs1, w_use_rs2;
    always_comb begin
        w_legal   = 1'b0;
        w_ebreak  = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                case (w_f3)
                    F3_SLL:  w_legal = (w_f7 == 7'h00);
                    F3_SR:   w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                    default: w_legal = 1'b1;
                endcase
            end
            OP: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if ((w_f3 == F3_ADD) || (w_f3 == F3_SR)) begin
                    w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
                end else begin
                    w_legal = (w_f7 == 7'h00);
                end
            end
            LUI, AUIPC, JAL: begin
                w_use_rd = 1'b1;
                w_legal  = 1'b1;
            end
            JALR: begin
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_legal   = (w_f3 == 3'b000);
            end
            BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
            end
            SYSTEM: begin
                w_ebreak = (r_ir == INST_EBREAK);
                w_legal  = w_ebreak;
            end
            default: ;
        endcase
    end

    // RV32E: any referenced register index >= 16 is a fault.
    logic w_bad_reg;
    assign w_bad_reg = (NR_REG < 32) &&
                       ((w_use_rd && w_rd[4]) || (w_use_rs1 && w_rs1[4]) || (w_use_rs2 && w_rs2[4]));

    // ALU
    logic [XLEN-1:0] w_alu_b, w_alu, w_sra;
    logic [4:0]      w_shamt;
    assign w_alu_b = (w_opcode == OP) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];
    // Kept as its own signal so the arithmetic shift stays signed.
    assign w_sra   = $signed(w_rs1_val) >>> w_shamt;

    always_comb begin
        case (w_f3)
            F3_ADD:  w_alu = ((w_opcode == OP) && w_f7[5]) ? (w_rs1_val - w_alu_b)
                                                            : (w_rs1_val + w_alu_b);
            F3_SLL:  w_alu = w_rs1_val << w_shamt;
            F3_SLT:  w_alu = XLEN'($signed(w_rs1_val) < $signed(w_alu_b));
            F3_SLTU: w_alu = XLEN'(w_rs1_val < w_alu_b);
            F3_XOR:  w_alu = w_rs1_val ^ w_alu_b;
            F3_SR:   w_alu = w_f7[5] ? w_sra : (w_rs1_val >> w_shamt);
            F3_OR:   w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

    // Branch condition
    logic w_eq, w_lt, w_ltu, w_taken;
    assign w_eq  = (w_rs1_val == w_rs2_val);
    assign w_lt  = $signed(w_rs1_val) < $signed(w_rs2_val);
    assign w_ltu = (w_rs1_val < w_rs2_val);
    always_comb begin
        case (w_f3)
            F3_BEQ:  w_taken = w_eq;
            F3_BNE:  w_taken = !w_eq;
            F3_BLT:  w_taken = w_lt;
            F3_BGE:  w_taken = !w_lt;
            F3_BLTU: w_taken = w_ltu;
            F3_BGEU: w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    // Next PC and write-back data
    logic [XLEN-1:0] w_pc_plus4, w_next_pc, w_jalr_sum;
    logic            w_redirect;
    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_jalr_sum = w_rs1_val + w_imm_i;

    always_comb begin
        w_next_pc  = w_pc_plus4;
        w_redirect = 1'b0;
        w_wdata    = w_alu;
        case (w_opcode)
            LUI:   w_wdata = w_imm_u;
            AUIPC: w_wdata = r_pc + w_imm_u;
            JAL: begin
                w_wdata    = w_pc_plus4;
                w_next_pc  = r_pc + w_imm_j;
                w_redirect = 1'b1;
            end
            JALR: begin
                w_wdata    = w_pc_plus4;
                w_next_pc  = {w_jalr_sum[XLEN-1:1], 1'b0};
                w_redirect = 1'b1;
            end
            BRANCH: begin
                if (w_taken) begin
                    w_next_pc  = r_pc + w_imm_b;
                    w_redirect = 1'b1;
                end
            end
            default: ;
        endcase
    end

    logic w_exec_fault, w_exec_ok;
    assign w_exec_fault = !w_legal || w_bad_reg || (w_redirect && w_next_pc[1]);
    assign w_exec_ok    = !w_exec_fault && !w_ebreak;
    assign w_rf_we      = commit && w_use_rd;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: if (ifu_req_ready) w_state_next = ST_WAIT;
            ST_WAIT:  if (ifu_resp_valid) w_state_next = ifu_resp_err ? ST_HALT : ST_EXEC;
            ST_EXEC:  w_state_next = w_exec_ok ? ST_FETCH : ST_HALT;
            default:  w_state_next = ST_HALT;
        endcase
    end

    // FSM: outputs. The state already sits in FETCH while reset is held, so the
    // request is gated with rst to keep the bus quiet until reset is released.
    always_comb begin
        ifu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;
        commit         = 1'b0;
        halt           = 1'b0;
        case (r_state)
            ST_FETCH: ifu_req_valid  = rst;
            ST_WAIT:  ifu_resp_ready = 1'b1;
            ST_EXEC:  commit         = w_exec_ok;
            default:  halt           = 1'b1;
        endcase
    end

    // Datapath state: IR capture, PC update, sticky fault.
    // The PC only moves on a commit, so a halt leaves it on the offending instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RST_PC;
            r_ir    <= '0;
            r_fault <= 1'b0;
        end else begin
            if ((r_state == ST_WAIT) && ifu_resp_valid) begin
                if (ifu_resp_err) begin
                    r_fault <= 1'b1;
                end else begin
                    r_ir <= ifu_resp_inst;
                end
            end
            if (r_state == ST_EXEC) begin
                if (w_exec_fault) begin
                    r_fault <= 1'b1;
                end else if (w_exec_ok) begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign ifu_req_addr = r_pc;
    assign pc           = r_pc;
    assign commit_pc    = commit ? r_pc : '0;
    assign fault        = r_fault;

endmodule

// File: tb/tb_ysyx_mc_core.sv
module tb_ysyx_mc_core;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // RV32I core
    logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, resp_inst, commit_pc, pc, dbg_data;
    logic        commit, halt, fault;
    logic [4:0]  dbg_addr;

    // RV32E core
    logic        rst_e, req_valid_e, req_ready_e, resp_valid_e, resp_ready_e, resp_err_e;
    logic [31:0] req_addr_e, resp_inst_e, commit_pc_e, pc_e, dbg_data_e;
    logic        commit_e, halt_e, fault_e;
    logic [4:0]  dbg_addr_e;

    ysyx_mc_core #(.XLEN(32), .NR_REG(32), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(req_valid), .ifu_req_ready(req_ready), .ifu_req_addr(req_addr),
        .ifu_resp_valid(resp_valid), .ifu_resp_ready(resp_ready),
        .ifu_resp_inst(resp_inst), .ifu_resp_err(resp_err),
        .commit(commit), .commit_pc(commit_pc), .halt(halt), .fault(fault), .pc(pc),
        .dbg_rf_addr(dbg_addr), .dbg_rf_data(dbg_data)
    );

    ysyx_mc_core #(.XLEN(32), .NR_REG(16), .RST_PC(RST_PC)) dut_e (
        .clk(clk), .rst(rst_e),
        .ifu_req_valid(req_valid_e), .ifu_req_ready(req_ready_e), .ifu_req_addr(req_addr_e),
        .ifu_resp_valid(resp_valid_e), .ifu_resp_ready(resp_ready_e),
        .ifu_resp_inst(resp_inst_e), .ifu_resp_err(resp_err_e),
        .commit(commit_e), .commit_pc(commit_pc_e), .halt(halt_e), .fault(fault_e), .pc(pc_e),
        .dbg_rf_addr(dbg_addr_e), .dbg_rf_data(dbg_data_e)
    );

    // 256-byte program window at RST_PC; everything else reads as EBREAK.
    logic [31:0] mem [64];

    function automatic logic [31:0] lookup(input logic [31:0] a);
        if (a[31:8] == 24'h80_0000) return mem[a[7:2]];
        return EBRK;
    endfunction

    task automatic mem_clear();
        for (int i = 0; i < 64; i++) mem[i] = EBRK;
    endtask

    // Memory answers with the word at the current PC; the PC is stable from FETCH to EXEC.
    always @(negedge clk) begin
        resp_inst   = lookup(req_addr);
        resp_inst_e = lookup(req_addr_e);
    end

    logic [31:0] cq [$];
    int          n_commit_e = 0;
    always @(negedge clk) begin
        if (commit) cq.push_back(commit_pc);
        if (commit_e) n_commit_e++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic rd_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halt && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halt"}, {31'b0, halt}, 32'd1);
    endtask

    logic [31:0] exp_pcs [8] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C,
                                 32'h8000_0010, 32'h8000_0018, 32'h8000_001C, 32'h8000_0020};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rst_e = 1'b1;
        req_ready = 1'b1; resp_valid = 1'b1; resp_err = 1'b0; dbg_addr = 5'd0;
        req_ready_e = 1'b1; resp_valid_e = 1'b1; resp_err_e = 1'b0; dbg_addr_e = 5'd0;
        resp_inst = EBRK; resp_inst_e = EBRK;
        mem_clear();
        #1;
        rst = 1'b0; rst_e = 1'b0;

        // ---- 1: reset state, addi x1,x0,5, then EBREAK ----
        mem[0] = 32'h0050_0093;
        repeat (2) @(negedge clk);
        chk("rst_pc",         pc,                  RST_PC);
        chk("rst_req_addr",   req_addr,            RST_PC);
        chk("rst_req_valid",  {31'b0, req_valid},  32'd0);
        chk("rst_resp_ready", {31'b0, resp_ready}, 32'd0);
        chk("rst_commit",     {31'b0, commit},     32'd0);
        chk("rst_commit_pc",  commit_pc,           32'd0);
        chk("rst_halt",       {31'b0, halt},       32'd0);
        chk("rst_fault",      {31'b0, fault},      32'd0);
        rd_reg("rst_x1", 5'd1, 32'd0);
        rst = 1'b1;
        #1;
        chk("t1_c1_req_valid", {31'b0, req_valid}, 32'd1);
        chk("t1_c1_req_addr",  req_addr,           RST_PC);
        @(negedge clk);
        chk("t1_c2_resp_ready", {31'b0, resp_ready}, 32'd1);
        chk("t1_c2_commit",     {31'b0, commit},     32'd0);
        @(negedge clk);
        chk("t1_c3_commit",    {31'b0, commit}, 32'd1);
        chk("t1_c3_commit_pc", commit_pc,       RST_PC);
        @(negedge clk);
        chk("t1_pc", pc, RST_PC + 32'd4);
        rd_reg("t1_x1", 5'd1, 32'd5);
        wait_halt("t1_ebreak", 20);
        chk("t1_ebreak_fault", {31'b0, fault}, 32'd0);
        chk("t1_ebreak_pc",    pc,             RST_PC + 32'd4);
        chk("t1_halt_idle",    {31'b0, req_valid | resp_ready}, 32'd0);

        // ---- 2/3/4: stalled fetch, ALU sequence, branches, JALR, misaligned target ----
        rst = 1'b0;
        mem_clear();
        mem[0]  = 32'h1234_5137; // lui  x2,0x12345
        mem[1]  = 32'h6781_0113; // addi x2,x2,0x678
        mem[2]  = 32'h4020_01B3; // sub  x3,x0,x2
        mem[3]  = 32'h0030_3233; // sltu x4,x0,x3
        mem[4]  = 32'h0000_0463; // beq  x0,x0,+8
        mem[5]  = 32'h0000_0000; // skipped (illegal)
        mem[6]  = 32'h8000_02B7; // lui  x5,0x80000
        mem[7]  = 32'h0030_4463; // blt  x0,x3,+8 (not taken: x3 negative)
        mem[8]  = 32'h0812_80E7; // jalr x1,x5,0x81 -> 0x80000080
        mem[32] = 32'h0822_8067; // jalr x0,x5,0x82 -> bit 1 set, fault
        req_ready = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        cq.delete();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req_valid",  {31'b0, req_valid},  32'd1);
            chk("t2_req_addr",   req_addr,            RST_PC);
            chk("t2_resp_ready", {31'b0, resp_ready}, 32'd0);
            chk("t2_commit",     {31'b0, commit},     32'd0);
            @(negedge clk);
        end
        req_ready = 1'b1;
        @(negedge clk);
        chk("t2_wait_a", {31'b0, resp_ready}, 32'd1);
        @(negedge clk);
        chk("t2_wait_b", {31'b0, resp_ready}, 32'd1);
        chk("t2_wait_commit", {31'b0, commit}, 32'd0);
        resp_valid = 1'b1;
        wait_halt("t3", 200);
        @(negedge clk);
        chk("t3_ncommit", cq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_commit_pc%0d", i), (i < cq.size()) ? cq[i] : 32'hDEAD_DEAD, exp_pcs[i]);
        end
        rd_reg("t3_x2", 5'd2, 32'h1234_5678);
        rd_reg("t3_x3", 5'd3, 32'hEDCB_A988);
        rd_reg("t3_x4", 5'd4, 32'd1);
        rd_reg("t4_x5", 5'd5, 32'h8000_0000);
        rd_reg("t4_x1", 5'd1, 32'h8000_0024);
        rd_reg("t4_x0", 5'd0, 32'd0);
        chk("t4_fault",    {31'b0, fault},     32'd1);
        chk("t4_halt_pc",  pc,                 32'h8000_0080);
        chk("t4_idle",     {31'b0, req_valid | resp_ready}, 32'd0);

        // ---- 5a: RV32E, addi x17,x0,1 ----
        rst = 1'b0;
        mem_clear();
        mem[0] = 32'h0010_0893;
        dbg_addr_e = 5'd17;
        @(negedge clk);
        rst_e = 1'b1;
        begin
            int n = 0;
            while (!halt_e && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        repeat (2) @(negedge clk);
        chk("t5e_halt",    {31'b0, halt_e},  32'd1);
        chk("t5e_fault",   {31'b0, fault_e}, 32'd1);
        chk("t5e_commits", n_commit_e,       32'd0);
        chk("t5e_pc",      pc_e,             RST_PC);
        chk("t5e_idle",    {31'b0, req_valid_e | resp_ready_e}, 32'd0);
        chk("t5e_x17",     dbg_data_e,       32'd0);

        // ---- 5b: bus error on the response ----
        mem[0] = 32'h0050_0093;
        resp_err = 1'b1;
        cq.delete();
        @(negedge clk);
        rst = 1'b1;
        wait_halt("t5b", 20);
        resp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5b_fault",   {31'b0, fault}, 32'd1);
        chk("t5b_commits", cq.size(),      32'd0);
        chk("t5b_pc",      pc,             RST_PC);
        chk("t5b_idle",    {31'b0, req_valid | resp_ready}, 32'd0);
        rd_reg("t5b_x1", 5'd1, 32'd0);

        // ---- 6: async reset while in WAIT ----
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        begin
            int n = 0;
            while (!commit && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_first_commit", {31'b0, commit}, 32'd1);
            n = 0;
            @(negedge clk);
            while (!resp_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_in_wait", {31'b0, resp_ready}, 32'd1);
        end
        rd_reg("t6_x1_before", 5'd1, 32'd5);
        rst = 1'b0;
        #1;
        chk("t6_pc",         pc,                  RST_PC);
        chk("t6_req_addr",   req_addr,            RST_PC);
        chk("t6_req_valid",  {31'b0, req_valid},  32'd0);
        chk("t6_resp_ready", {31'b0, resp_ready}, 32'd0);
        chk("t6_halt",       {31'b0, halt},       32'd0);
        rd_reg("t6_x1_after", 5'd1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_refetch_valid", {31'b0, req_valid}, 32'd1);
        chk("t6_refetch_addr",  req_addr,           RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
